// File: rtl/button_conditioner.sv
// Conditions four raw game buttons: 2-FF sync into clk_25_175, counter debounce, one-cycle press events.
// Defining AUTOREPEAT_EN adds per-button autorepeat (L/R/D only); undefined gives press events only.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 4000000,
  parameter int REPEAT_RATE     = 1250000
) (
  input  logic       clk_25_175,
  input  logic       reset,
  input  logic [3:0] butt_raw,
  output logic [3:0] butt_level,
  output logic [3:0] butt_evt,
  output logic [3:0] butt_repeat
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 2");
  end

  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level_d;
  logic [CW-1:0] cnt [4];
  logic [3:0]    press;

  // NOTE: the counter array is tiny and must start at zero, so it is reset like any other
  // register; large storage arrays would normally be left out of the reset.
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      butt_level <= '0;
      level_d    <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving two real flops.
      sync1   <= butt_raw;
      sync2   <= sync1;
      level_d <= butt_level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == butt_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          butt_level[i] <= sync2[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = butt_level & ~level_d;

`ifdef AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} ar_state_t;

  localparam int            TMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            TW         = $clog2(TMAX);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [3:0]    AR_MASK    = 4'b1101;  // T (bit 1) never repeats

  ar_state_t     state [4];
  logic [TW-1:0] timer [4];
  logic [3:0]    fall_now;
  logic [3:0]    cancel;
  logic          lr_both;

  // Cancel in the same cycle the stable level drops, not a cycle later.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fall_now = '0;
    for (int i = 0; i < 4; i++)
      fall_now[i] = butt_level[i] & ~sync2[i] & (cnt[i] == CNT_LAST);
    lr_both   = butt_level[0] & butt_level[2];
    cancel    = fall_now | ~AR_MASK;
    cancel[0] = cancel[0] | lr_both;
    cancel[2] = cancel[2] | lr_both;
  end

  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) begin
      butt_evt    <= '0;
      butt_repeat <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        butt_evt[i] <= press[i];
        if (cancel[i]) begin
          state[i]       <= IDLE;
          timer[i]       <= '0;
          butt_repeat[i] <= 1'b0;
        end else begin
          case (state[i])
            IDLE: begin
              if (press[i]) begin
                state[i] <= DELAY;
                timer[i] <= '0;
              end
            end
            DELAY: begin
              if (timer[i] == DELAY_LAST) begin
                butt_evt[i]    <= 1'b1;
                butt_repeat[i] <= 1'b1;
                state[i]       <= REPEAT;
                timer[i]       <= '0;
              end else begin
                timer[i] <= timer[i] + 1'b1;
              end
            end
            REPEAT: begin
              if (timer[i] == RATE_LAST) begin
                butt_evt[i] <= 1'b1;
                timer[i]    <= '0;
              end else begin
                timer[i] <= timer[i] + 1'b1;
              end
            end
            default: begin
              state[i]       <= IDLE;
              timer[i]       <= '0;
              butt_repeat[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge clk_25_175 or posedge reset) begin
    if (reset) butt_evt <= '0;
    else       butt_evt <= press;
  end

  assign butt_repeat = 4'b0000;
`endif

endmodule
